// File: rtl/fasm_dparam_sc.sv
// Dual-port flop-based register array: two independent synchronous write
// ports, two combinational read ports, asynchronous active-low clear.
module fasm_dparam_sc #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] adr_i,
  input  logic [DW-1:0] dat_i,
  input  logic          wre_i,
  input  logic          stb_i,
  output logic [DW-1:0] dat_o,
  input  logic [AW-1:0] xadr_i,
  input  logic [DW-1:0] xdat_i,
  input  logic          xwre_i,
  input  logic          xstb_i,
  output logic [DW-1:0] xdat_o
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];

  // Strobes are reserved pins; they intentionally gate nothing.
  logic unused_strobes;
  assign unused_strobes = stb_i ^ xstb_i;

  // One register per word; port X is checked first so it wins a collision.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      logic [DW-1:0] word_reg;
      logic [DW-1:0] word_next;
      logic          hit_a;
      logic          hit_x;

      assign hit_a = wre_i  && (adr_i  == AW'(gi));
      assign hit_x = xwre_i && (xadr_i == AW'(gi));

      always_comb begin
        word_next = word_reg;
        if (hit_x) begin
          word_next = xdat_i;
        end else if (hit_a) begin
          word_next = dat_i;
        end
      end

      always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
          word_reg <= '0;
        end else begin
          word_reg <= word_next;
        end
      end

      assign mem_q[gi] = word_reg;
    end
  endgenerate

  // No bypass: a same-cycle write is visible only after the edge.
  assign dat_o  = mem_q[adr_i];
  assign xdat_o = mem_q[xadr_i];

endmodule

// File: tb/tb_fasm_dparam_sc.sv
// Scoreboard bench for fasm_dparam_sc: stimulus queues expected read data,
// a monitor process compares both read ports when a check is presented.
module tb_fasm_dparam_sc;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [4:0]  adr_i = '0;
  logic [31:0] dat_i = '0;
  logic        wre_i = 1'b0;
  logic        stb_i = 1'b0;
  logic [31:0] dat_o;
  logic [4:0]  xadr_i = '0;
  logic [31:0] xdat_i = '0;
  logic        xwre_i = 1'b0;
  logic        xstb_i = 1'b0;
  logic [31:0] xdat_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [4:0]  a;
    logic [31:0] ea;
    logic [4:0]  xa;
    logic [31:0] exa;
  } exp_t;

  exp_t sb[$];
  event chk_ev;

  fasm_dparam_sc #(.AW(5), .DW(32)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .adr_i (adr_i),
    .dat_i (dat_i),
    .wre_i (wre_i),
    .stb_i (stb_i),
    .dat_o (dat_o),
    .xadr_i(xadr_i),
    .xdat_i(xdat_i),
    .xwre_i(xwre_i),
    .xstb_i(xstb_i),
    .xdat_o(xdat_o)
  );

  always #5 clk_i = ~clk_i;

  // Present addresses, queue the expected read data, signal the monitor.
  task automatic chk(input string nm, input logic [4:0] a, input logic [31:0] ea,
                     input logic [4:0] xa, input logic [31:0] exa);
    exp_t e;
    adr_i  = a;
    xadr_i = xa;
    e.name = nm; e.a = a; e.ea = ea; e.xa = xa; e.exa = exa;
    sb.push_back(e);
    -> chk_ev;
    #2;
  endtask

  task automatic wr(input logic a_en, input logic [4:0] a, input logic [31:0] d,
                    input logic x_en, input logic [4:0] xa, input logic [31:0] xd);
    @(negedge clk_i);
    wre_i = a_en;  adr_i  = a;  dat_i  = d;
    xwre_i = x_en; xadr_i = xa; xdat_i = xd;
    @(posedge clk_i);
    #1;
    wre_i = 1'b0;
    xwre_i = 1'b0;
    $display("write a_en=%0b a=%0d d=%h x_en=%0b xa=%0d xd=%h", a_en, a, d, x_en, xa, xd);
  endtask

  // Monitor: pop one expectation per presented check and compare both ports.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      #1;
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL sb_underflow: got no expectation, required one");
      end else begin
        e = sb.pop_front();
        checks++;
        if (dat_o !== e.ea) begin
          errors++;
          $display("FAIL %s dat_o adr=%0d: got %h required %h", e.name, e.a, dat_o, e.ea);
        end else begin
          $display("check %s dat_o adr=%0d = %h", e.name, e.a, dat_o);
        end
        checks++;
        if (xdat_o !== e.exa) begin
          errors++;
          $display("FAIL %s xdat_o xadr=%0d: got %h required %h", e.name, e.xa, xdat_o, e.exa);
        end else begin
          $display("check %s xdat_o xadr=%0d = %h", e.name, e.xa, xdat_o);
        end
      end
    end
  end

  initial begin
    #3;
    chk("reset_state", 5'd0, 32'h0, 5'd31, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Populate a few words, then clear them asynchronously between edges.
    wr(1'b1, 5'd1, 32'hA5A5_0001, 1'b1, 5'd2, 32'h5A5A_0002);
    wr(1'b1, 5'd20, 32'h0BAD_F00D, 1'b1, 5'd30, 32'hFEED_0030);
    chk("prefill", 5'd1, 32'hA5A5_0001, 5'd30, 32'hFEED_0030);
    @(negedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      chk("async_clear", 5'(i), 32'h0, 5'(31 - i), 32'h0);
    end
    wr(1'b1, 5'd4, 32'hFFFF_FFFF, 1'b1, 5'd5, 32'hEEEE_EEEE);
    chk("write_in_reset", 5'd4, 32'h0, 5'd5, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    chk("post_release", 5'd1, 32'h0, 5'd20, 32'h0);

    wr(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hDEAD_BEEF);
    chk("x_write", 5'd7, 32'hDEAD_BEEF, 5'd7, 32'hDEAD_BEEF);
    chk("x_write_nbr", 5'd6, 32'h0, 5'd7, 32'hDEAD_BEEF);

    wr(1'b1, 5'd31, 32'h1234_5678, 1'b0, 5'd0, 32'h0);
    chk("a_write", 5'd0, 32'h0, 5'd31, 32'h1234_5678);

    wr(1'b1, 5'd3, 32'h1111_1111, 1'b0, 5'd0, 32'h0);
    @(negedge clk_i);
    xwre_i = 1'b1; xdat_i = 32'h2222_2222;
    chk("rdw_before", 5'd3, 32'h1111_1111, 5'd3, 32'h1111_1111);
    @(posedge clk_i);
    #1;
    xwre_i = 1'b0;
    chk("rdw_after", 5'd3, 32'h2222_2222, 5'd3, 32'h2222_2222);

    wr(1'b1, 5'd9, 32'hAAAA_AAAA, 1'b1, 5'd9, 32'h5555_5555);
    chk("collide_same", 5'd9, 32'h5555_5555, 5'd9, 32'h5555_5555);
    wr(1'b1, 5'd9, 32'hCAFE_0009, 1'b1, 5'd10, 32'hBEEF_000A);
    chk("dual_diff", 5'd9, 32'hCAFE_0009, 5'd10, 32'hBEEF_000A);

    stb_i = 1'b0; xstb_i = 1'b0;
    wr(1'b1, 5'd12, 32'h0C0C_0C0C, 1'b1, 5'd13, 32'h0D0D_0D0D);
    chk("strobe_low", 5'd12, 32'h0C0C_0C0C, 5'd13, 32'h0D0D_0D0D);

    // Enables low: random data and addresses must not disturb contents.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      adr_i = 5'($urandom);  dat_i = $urandom;
      xadr_i = 5'($urandom); xdat_i = $urandom;
      stb_i = 1'($urandom);  xstb_i = 1'($urandom);
    end
    @(negedge clk_i);
    chk("hold_3_7", 5'd3, 32'h2222_2222, 5'd7, 32'hDEAD_BEEF);
    chk("hold_9_10", 5'd9, 32'hCAFE_0009, 5'd10, 32'hBEEF_000A);
    chk("hold_12_13", 5'd12, 32'h0C0C_0C0C, 5'd13, 32'h0D0D_0D0D);
    chk("hold_31_0", 5'd31, 32'h1234_5678, 5'd0, 32'h0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) #1;
    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL sb_drain: got %0d pending, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
